// File: rtl/prod_acc_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding,
// default accumulator width and a readout byte helper.
package prod_acc_pkg;

   // Default accumulator width in bits (legal range 9..16)
   localparam int ACC_W_DEFAULT = 16;

   // Readout FSM: accumulate, then emit low byte, then high byte
   typedef enum logic [1:0] {
      ACC    = 2'd0,
      OUT_LO = 2'd1,
      OUT_HI = 2'd2
   } state_t;

   // High readout byte of a value up to 16 bits wide; callers zero-extend
   // narrower accumulators, so unused upper bits come out as zero
   function automatic logic [7:0] hi_byte(input logic [15:0] value);
      return value[15:8];
   endfunction

endpackage

// File: rtl/prod_accumulator_if.sv
// Product input handshake, control strobes, byte readout and status
// bundled as one interface between the accumulator and its user.
interface prod_accumulator_if;

   logic [7:0] prod_in;
   logic       in_valid;
   logic       in_ready;
   logic       acc_clr;
   logic       rd_start;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_last;
   logic       overflow;
   logic [3:0] count;

   // Driver side: supplies products and control, consumes readout/status
   modport master (
      output prod_in, in_valid, acc_clr, rd_start,
      input  in_ready, out_byte, out_valid, out_last, overflow, count
   );

   // Accumulator side
   modport slave (
      input  prod_in, in_valid, acc_clr, rd_start,
      output in_ready, out_byte, out_valid, out_last, overflow, count
   );

endinterface

// File: rtl/prod_accumulator.sv
// Accumulates 8-bit multiplier products into an ACC_W-bit register and
// reads the total out as two bytes (low first, high marked last).
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int ACC_W       = ACC_W_DEFAULT,
   parameter bit CLR_ON_READ = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   prod_accumulator_if.slave bus
);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] snap;
   logic [3:0]       cnt;
   logic             ovf;
   logic [7:0]       rd_byte;
   logic             rd_valid;
   logic             rd_last;

   logic             accept;
   logic [ACC_W:0]   sum;

   assign bus.in_ready  = (state == ACC);
   assign bus.out_byte  = rd_byte;
   assign bus.out_valid = rd_valid;
   assign bus.out_last  = rd_last;
   assign bus.overflow  = ovf;
   assign bus.count     = cnt;

   // Adder with carry out; a product presented with acc_clr is dropped
   always_comb begin
      accept = bus.in_valid && (state == ACC) && !bus.acc_clr;
      sum    = {1'b0, acc};
      if (accept) begin
         sum = {1'b0, acc} + {1'b0, {(ACC_W-8){1'b0}}, bus.prod_in};
      end
   end

   // FSM, accumulator, status and registered readout outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ACC;
         acc      <= '0;
         snap     <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         rd_byte  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         unique case (state)
            ACC: begin
               rd_byte  <= '0;
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
               if (bus.acc_clr) begin
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
               end else begin
                  acc <= sum[ACC_W-1:0];
                  if (sum[ACC_W]) begin
                     ovf <= 1'b1;
                  end
                  if (accept && (cnt != 4'd15)) begin
                     cnt <= cnt + 4'd1;
                  end
                  // Snapshot includes a product accepted in this same cycle
                  if (bus.rd_start) begin
                     state    <= OUT_LO;
                     snap     <= sum[ACC_W-1:0];
                     rd_byte  <= sum[7:0];
                     rd_valid <= 1'b1;
                  end
               end
            end
            OUT_LO: begin
               // Readout runs from the snapshot, so clearing cannot disturb it
               state    <= OUT_HI;
               rd_byte  <= hi_byte(16'(snap));
               rd_valid <= 1'b1;
               rd_last  <= 1'b1;
               if (bus.acc_clr) begin
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
               end
            end
            OUT_HI: begin
               state    <= ACC;
               rd_byte  <= '0;
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
               if (bus.acc_clr || CLR_ON_READ) begin
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
               end
            end
            default: begin
               state    <= ACC;
               rd_byte  <= '0;
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: stimulus pushes expected readout
// bytes into a queue, a negedge monitor pops and compares them.
module tb_prod_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;

   prod_accumulator_if bus();

   prod_accumulator #(.ACC_W(16), .CLR_ON_READ(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];   // {byte, last}

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [7:0] p);
      bus.in_valid = 1'b1;
      bus.prod_in  = p;
      cycle();
      bus.in_valid = 1'b0;
   endtask

   // Issue rd_start (optionally with a product) and expect a full readout
   task automatic do_read(input bit with_prod, input logic [7:0] p,
                          input logic [7:0] lo, input logic [7:0] hi, input string tag);
      exp_q.push_back({lo, 1'b0});
      exp_q.push_back({hi, 1'b1});
      bus.rd_start = 1'b1;
      bus.in_valid = with_prod;
      bus.prod_in  = p;
      cycle();
      bus.rd_start = 1'b0;
      bus.in_valid = 1'b0;
      check({tag, " in_ready_lo"}, 16'(bus.in_ready), 16'h0);
      cycle();
      check({tag, " in_ready_hi"}, 16'(bus.in_ready), 16'h0);
      cycle();
      check({tag, " in_ready_after"}, 16'(bus.in_ready), 16'h1);
      check({tag, " count_after"}, 16'(bus.count), 16'h0);
      check({tag, " overflow_after"}, 16'(bus.overflow), 16'h0);
   endtask

   // Monitor: every readout byte must match the head of the queue
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 16'(bus.out_byte), 16'hDEAD);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("out_byte", 16'(bus.out_byte), 16'(e[8:1]));
               check("out_last", 16'(bus.out_last), 16'(e[0]));
            end
         end else begin
            check("idle_byte_last", {7'd0, bus.out_last, bus.out_byte}, 16'h0);
         end
      end
   end

   initial begin
      bus.prod_in  = 8'h00;
      bus.in_valid = 1'b0;
      bus.acc_clr  = 1'b0;
      bus.rd_start = 1'b0;

      // Reset state
      cycle();
      cycle();
      check("rst out_valid", 16'(bus.out_valid), 16'h0);
      check("rst out_byte", 16'(bus.out_byte), 16'h0);
      check("rst count", 16'(bus.count), 16'h0);
      check("rst overflow", 16'(bus.overflow), 16'h0);
      rst = 1'b0;
      check("rst in_ready_first", 16'(bus.in_ready), 16'h1);

      // 4 x 0xE1 = 0x0384
      for (int i = 0; i < 4; i++) accept(8'hE1);
      check("e1 count", 16'(bus.count), 16'h4);
      check("e1 overflow", 16'(bus.overflow), 16'h0);
      do_read(1'b0, 8'h00, 8'h84, 8'h03, "e1");

      // 257 x 0xFF = 0xFFFF, no overflow, count saturated
      for (int i = 0; i < 257; i++) accept(8'hFF);
      check("ff count_sat", 16'(bus.count), 16'hF);
      check("ff overflow", 16'(bus.overflow), 16'h0);
      do_read(1'b0, 8'h00, 8'hFF, 8'hFF, "ff");

      // Same again plus 0x01 wraps to 0x0000 with overflow
      for (int i = 0; i < 257; i++) accept(8'hFF);
      accept(8'h01);
      check("wrap overflow", 16'(bus.overflow), 16'h1);
      check("wrap count", 16'(bus.count), 16'hF);
      do_read(1'b0, 8'h00, 8'h00, 8'h00, "wrap");

      // 0x0010 + product 0x05 accepted on the rd_start cycle -> 0x0015
      accept(8'h10);
      do_read(1'b1, 8'h05, 8'h15, 8'h00, "same_cycle");

      // acc_clr beats rd_start and a concurrent product
      accept(8'h80);
      accept(8'h80);
      check("clr pre_count", 16'(bus.count), 16'h2);
      bus.acc_clr  = 1'b1;
      bus.in_valid = 1'b1;
      bus.prod_in  = 8'h07;
      bus.rd_start = 1'b1;
      #1;
      check("clr in_ready", 16'(bus.in_ready), 16'h1);
      cycle();
      bus.acc_clr  = 1'b0;
      bus.in_valid = 1'b0;
      bus.rd_start = 1'b0;
      check("clr count", 16'(bus.count), 16'h0);
      check("clr no_readout", 16'(bus.out_valid), 16'h0);
      cycle();
      check("clr still_acc", 16'(bus.in_ready), 16'h1);
      do_read(1'b0, 8'h00, 8'h00, 8'h00, "clr_zero");

      // acc_clr during OUT_LO, rd_start during OUT_HI: readout unaffected
      for (int i = 0; i < 3; i++) accept(8'hAB);
      accept(8'h55);   // 0x0256
      exp_q.push_back({8'h56, 1'b0});
      exp_q.push_back({8'h02, 1'b1});
      bus.rd_start = 1'b1;
      cycle();
      bus.rd_start = 1'b0;
      bus.acc_clr  = 1'b1;
      cycle();
      bus.acc_clr  = 1'b0;
      check("midclr count", 16'(bus.count), 16'h0);
      bus.rd_start = 1'b1;
      cycle();
      bus.rd_start = 1'b0;
      check("midclr back_acc", 16'(bus.in_ready), 16'h1);
      cycle();
      cycle();
      do_read(1'b0, 8'h00, 8'h00, 8'h00, "midclr_zero");

      // rst during OUT_LO aborts the readout immediately
      accept(8'h22);
      exp_q.push_back({8'h22, 1'b0});
      bus.rd_start = 1'b1;
      cycle();
      bus.rd_start = 1'b0;
      check("abort lo_valid", 16'(bus.out_valid), 16'h1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort out_valid", 16'(bus.out_valid), 16'h0);
      check("abort out_last", 16'(bus.out_last), 16'h0);
      check("abort in_ready", 16'(bus.in_ready), 16'h1);
      cycle();
      rst = 1'b0;
      check("abort in_ready_after", 16'(bus.in_ready), 16'h1);
      for (int i = 0; i < 4; i++) cycle();
      accept(8'h09);
      do_read(1'b0, 8'h00, 8'h09, 8'h00, "post_abort");

      cycle();
      cycle();
      check("queue_empty", 16'(exp_q.size()), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter ACC_W SHALL default to 16: accumulator width in bits; legal range 9..16, and the byte readout always sends two bytes.
REQ-002 Parameter CLR_ON_READ SHALL default to 1: when 1, a completed readout clears the accumulator, count and overflow.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port prod_in, input, 8: unsigned 8-bit product from the 4x4 array multiplier.
REQ-007 Port in_valid, input, 1: prod_in is valid this cycle.
REQ-008 Port in_ready, output, 1: the block can accept a product this cycle.
REQ-009 Port acc_clr, input, 1: synchronous clear of accumulator, count and overflow.
REQ-010 Port rd_start, input, 1: request a two-byte readout.
REQ-011 Port out_byte, output, 8: readout data byte.
REQ-012 Port out_valid, output, 1: out_byte is valid this cycle.
REQ-013 Port out_last, output, 1: marks the high (final) readout byte.
REQ-014 Port overflow, output, 1: sticky flag, set on carry out of bit ACC_W-1.
REQ-015 Port count, output, 4: number of accepted products, saturating at 15.

Function
REQ-016 The FSM SHALL have exactly three states: ACC, OUT_LO and OUT_HI.
REQ-017 ACC SHALL move to OUT_LO on rd_start=1 with acc_clr=0; in every other case it stays in ACC.
REQ-018 The FSM SHALL move OUT_LO to OUT_HI and OUT_HI to ACC unconditionally, so a readout takes exactly 2 cycles with no backpressure.
REQ-019 in_ready SHALL be 1 only in ACC.
REQ-020 A product SHALL be accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-021 An accepted product SHALL zero-extend prod_in to ACC_W bits and add it to the accumulator, updating it one cycle later.
REQ-022 The accumulator sum SHALL wrap modulo 2^ACC_W, and overflow SHALL set on that wrap.
REQ-023 count SHALL increment on each accepted product and hold at 15.
REQ-024 On the rd_start cycle the block SHALL snapshot acc + (accepted product, if any), so a product accepted in that cycle is included.
REQ-025 In OUT_LO: out_valid=1, out_last=0, out_byte = snapshot[7:0].
REQ-026 In OUT_HI: out_valid=1, out_last=1, out_byte = snapshot[ACC_W-1:8], zero-padded to 8 bits.
REQ-027 In ACC: out_valid=0, out_last=0, out_byte=0.
REQ-028 With CLR_ON_READ=1, leaving OUT_HI SHALL zero the accumulator, count and overflow.
REQ-029 acc_clr SHALL have priority over accumulation and rd_start; a product presented in the same cycle is dropped, and in_ready still reads 1.
REQ-030 acc_clr during OUT_LO or OUT_HI SHALL clear the accumulator, count and overflow but SHALL NOT abort or alter the readout in progress.
REQ-031 rd_start asserted in OUT_LO or OUT_HI SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force state ACC, accumulator 0, snapshot 0, count 0, overflow 0, out_byte 0, out_valid 0 and out_last 0, independent of clk.
REQ-033 rst asserted mid-readout SHALL abort it, with no further out_valid until a new rd_start.
REQ-034 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-035 The state encoding (ACC, OUT_LO, OUT_HI) and the ACC_W default SHALL live in a shared package, prod_acc_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the adder is inline.

Verification
REQ-037 Reset, then accept 0xE1 four times, then rd_start -> out_byte 0x84 (out_last=0), then 0x03 (out_last=1); count was 4; overflow 0.
REQ-038 Accept 0xFF 257 times -> acc 0xFFFF, overflow 0; accept 0x01 -> acc 0x0000, overflow 1, count 15.
REQ-039 Hold acc 0x0010 and assert in_valid with prod_in 0x05 together with rd_start -> bytes 0x15, 0x00; in_ready 0 for the following 2 cycles.
REQ-040 Hold acc 0x0100 and assert acc_clr with in_valid (0x07) and rd_start -> no readout; next cycle acc 0, count 0.
REQ-041 Assert acc_clr during OUT_LO -> OUT_HI byte still equals the snapshot high byte; acc 0 afterwards.
REQ-042 Assert rst during OUT_LO -> out_valid 0 immediately; state ACC; in_ready 1.
